// File: rtl/rr_decoder_arbiter_8_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding and bank geometry.
package rr_decoder_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_decoder_arbiter_8_if.sv
// Requester-bank / resource-select bundle between the arbiter and its clients.
interface rr_decoder_arbiter_8_if;
  import rr_decoder_arbiter_8_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               busy;

  // master = requester side, slave = arbiter
  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, busy
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, busy
  );

endinterface

// File: rtl/rr_decoder_arbiter_8_decoder.sv
// 3-to-8 line decoder with enable; {x,y,z} selects the asserted output, x is MSB.
module decoder_3_to_8 (
  input  logic       x,
  input  logic       y,
  input  logic       z,
  input  logic       en,
  output logic [7:0] w
);

  always_comb begin
    w = '0;
    if (en) w[{x, y, z}] = 1'b1;
  end

endmodule

// File: rtl/rr_decoder_arbiter_8.sv
// Round-robin arbiter for 8 requesters with bounded tenure and a guaranteed
// dead cycle between grants; the one-hot select is produced by a 3-to-8 decoder.
module rr_decoder_arbiter_8
  import rr_decoder_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_decoder_arbiter_8_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_valid;
  logic             tenure_end;

  // First requester found scanning upward from p, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] j;
    logic             found;
    win   = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = p + IDX_W'(k);
      if (!found && r[j]) begin
        win   = j;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tenure_end = bus.done || !bus.req[idx_q] || (cnt_q == HOLD_LIM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          idx_d   = rr_pick(bus.req, ptr_q);
          cnt_d   = CNT_W'(1);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Any combination of release causes collapses into one exit.
        if (tenure_end) begin
          ptr_d   = idx_q + IDX_W'(1);
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_valid     = (state_q == ST_GRANT);
  assign bus.grant_valid = grant_valid;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.grant_idx   = idx_q;

  decoder_3_to_8 u_dec (
    .x  (idx_q[2]),
    .y  (idx_q[1]),
    .z  (idx_q[0]),
    .en (grant_valid),
    .w  (bus.grant)
  );

endmodule

// File: tb/tb_rr_decoder_arbiter_8.sv
// Directed bench for rr_decoder_arbiter_8: a vector table for the grant/gap
// sequencing plus hand sequences for rotation wrap and asynchronous reset.
module tb_rr_decoder_arbiter_8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_decoder_arbiter_8_if bus ();

  rr_decoder_arbiter_8 #(.HOLD_MAX(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       vld;
    logic       busy;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req  = 8'h00;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] exp_g;
    total    = 0;
    bad      = 0;
    one      = 8'h01;
    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;

    // req, done -> grant, valid, busy, idx after the following edge
    vecs[0]  = '{8'h04, 1'b0, 8'h04, 1'b1, 1'b1, 3'd2};
    vecs[1]  = '{8'h04, 1'b0, 8'h04, 1'b1, 1'b1, 3'd2};
    vecs[2]  = '{8'h04, 1'b1, 8'h00, 1'b0, 1'b1, 3'd2};
    vecs[3]  = '{8'h0C, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2};
    vecs[4]  = '{8'h0C, 1'b0, 8'h08, 1'b1, 1'b1, 3'd3};
    vecs[5]  = '{8'h0C, 1'b0, 8'h08, 1'b1, 1'b1, 3'd3};
    vecs[6]  = '{8'h0C, 1'b0, 8'h08, 1'b1, 1'b1, 3'd3};
    vecs[7]  = '{8'h0C, 1'b0, 8'h08, 1'b1, 1'b1, 3'd3};
    vecs[8]  = '{8'h0C, 1'b1, 8'h00, 1'b0, 1'b1, 3'd3};
    vecs[9]  = '{8'h0C, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3};
    vecs[10] = '{8'h0C, 1'b0, 8'h04, 1'b1, 1'b1, 3'd2};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2};
    vecs[12] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2};
    vecs[13] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2};
    vecs[14] = '{8'h30, 1'b0, 8'h10, 1'b1, 1'b1, 3'd4};
    vecs[15] = '{8'h30, 1'b0, 8'h10, 1'b1, 1'b1, 3'd4};
    vecs[16] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4};
    vecs[17] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4};
    vecs[18] = '{8'h20, 1'b0, 8'h20, 1'b1, 1'b1, 3'd5};
    vecs[19] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5};
    vecs[20] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5};

    // Reset held with every requester active
    step();
    step();
    check("rst grant", bus.grant, 8'h00);
    check("rst valid", {7'd0, bus.grant_valid}, 8'h00);
    check("rst busy",  {7'd0, bus.busy}, 8'h00);
    check("rst idx",   {5'd0, bus.grant_idx}, 8'h00);

    // Table: single request with done, done+limit collision, drop, pointer moves
    do_reset();
    for (int i = 0; i < 21; i++) begin
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      step();
      check($sformatf("v%0d grant", i), bus.grant, vecs[i].grant);
      check($sformatf("v%0d valid", i), {7'd0, bus.grant_valid}, {7'd0, vecs[i].vld});
      check($sformatf("v%0d busy", i),  {7'd0, bus.busy}, {7'd0, vecs[i].busy});
      check($sformatf("v%0d idx", i),   {5'd0, bus.grant_idx}, {5'd0, vecs[i].idx});
    end
    bus.done = 1'b0;

    // All requesting: full rotation with wrap 7 -> 0, each tenure at the limit
    do_reset();
    bus.req = 8'hFF;
    for (int t = 0; t < 9; t++) begin
      exp_g = one << (t % 8);
      for (int c = 0; c < 4; c++) begin
        step();
        check($sformatf("rot t%0d c%0d grant", t, c), bus.grant, exp_g);
      end
      step();
      check($sformatf("rot t%0d gap grant", t), bus.grant, 8'h00);
      check($sformatf("rot t%0d gap busy", t), {7'd0, bus.busy}, 8'h01);
      step();
      check($sformatf("rot t%0d idle grant", t), bus.grant, 8'h00);
      check($sformatf("rot t%0d idle busy", t), {7'd0, bus.busy}, 8'h00);
    end

    // Asynchronous reset in the middle of a tenure, no clock edge involved
    do_reset();
    bus.req = 8'h08;
    step();
    check("async pre grant", bus.grant, 8'h08);
    step();
    check("async pre grant2", bus.grant, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("async drop grant", bus.grant, 8'h00);
    check("async drop valid", {7'd0, bus.grant_valid}, 8'h00);
    check("async drop busy",  {7'd0, bus.busy}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("async restart grant", bus.grant, 8'h08);
    check("async restart idx", {5'd0, bus.grant_idx}, 8'h03);

    // Pointer back at 0 after reset: lowest requester wins first
    do_reset();
    bus.req = 8'h81;
    step();
    check("ptr0 grant", bus.grant, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
